// File: rtl/sb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sb_cfg_pkg
// Shared definitions for the horizontal-channel switch block:
//   - SEL_BITS    : select bits per output track (fixed 4:1 encoding)
//   - SEL_*       : select codes (off / straight / i+1 / i-1)
//   - cfg_state_e : configuration controller states
//   - cfg_bits()  : configuration chain length for a given channel width
// ---------------------------------------------------------------------------
package sb_cfg_pkg;

    localparam int SEL_BITS = 2;

    localparam logic [SEL_BITS-1:0] SEL_OFF      = 2'd0;
    localparam logic [SEL_BITS-1:0] SEL_STRAIGHT = 2'd1;
    localparam logic [SEL_BITS-1:0] SEL_INC      = 2'd2;
    localparam logic [SEL_BITS-1:0] SEL_DEC      = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FULL   = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    // Two sides, each with chan_w tracks of SEL_BITS select bits.
    function automatic int cfg_bits(input int chan_w);
        return 2 * SEL_BITS * chan_w;
    endfunction

endpackage

// File: rtl/sb_track_mux4.sv
// ---------------------------------------------------------------------------
// sb_track_mux4
// One 4:1 output-track selector.
//   sel_i      : select code (SEL_OFF / SEL_STRAIGHT / SEL_INC / SEL_DEC)
//   straight_i : opposite-side track i
//   inc_i      : opposite-side track (i+1) mod W
//   dec_i      : opposite-side track (i-1) mod W
//   out_o      : driven output track (0 when off)
// ---------------------------------------------------------------------------
module sb_track_mux4
    import sb_cfg_pkg::*;
(
    input  logic [SEL_BITS-1:0] sel_i,
    input  logic                straight_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic                out_o
);

    always_comb begin
        out_o = 1'b0;
        unique case (sel_i)
            SEL_OFF:      out_o = 1'b0;
            SEL_STRAIGHT: out_o = straight_i;
            SEL_INC:      out_o = inc_i;
            SEL_DEC:      out_o = dec_i;
            default:      out_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sb_chanx_cfg.sv
// ---------------------------------------------------------------------------
// sb_chanx_cfg
// Horizontal-channel switch block with a double-buffered serial config chain.
//   prog_clk        : clock
//   pReset_n        : synchronous active-low reset
//   ccff_head       : serial config data in
//   ccff_en         : chain shift enable
//   ccff_tail       : serial config data out (last chain bit, registered)
//   cfg_commit      : pulse to copy the chain into the active register
//   cfg_full        : exactly CFG_BITS bits shifted since last commit/reset
//   cfg_done        : one-cycle pulse the cycle after a successful commit
//   cfg_err         : sticky flag, a commit was rejected
//   chanx_left_in   : left-side incoming tracks
//   chanx_right_in  : right-side incoming tracks
//   chanx_left_out  : left-side outgoing tracks  (sourced from right_in)
//   chanx_right_out : right-side outgoing tracks (sourced from left_in)
// Routing is combinational from the active register only, so shifting new
// configuration never disturbs live routing until the commit edge.
// ---------------------------------------------------------------------------
module sb_chanx_cfg
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_W = 32
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              ccff_head,
    input  logic              ccff_en,
    output logic              ccff_tail,
    input  logic              cfg_commit,
    output logic              cfg_full,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] chanx_right_in,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic [CHAN_W-1:0] chanx_right_out
);

    localparam int CFG_BITS = cfg_bits(CHAN_W);
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] chain_q, chain_d;
    logic [CFG_BITS-1:0] active_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cfg_state_e          state_q;
    logic                done_q;
    logic                err_q;
    logic                commit_ok;
    logic                commit_bad;

    // A commit is only honoured from FULL with no coincident shift.
    always_comb begin
        commit_ok  = cfg_commit && !ccff_en && (state_q == FULL);
        commit_bad = cfg_commit && !commit_ok;

        chain_d = chain_q;
        if (ccff_en) begin
            chain_d = {chain_q[CFG_BITS-2:0], ccff_head};
        end

        // Saturating count; extra shifts still move data through the chain.
        cnt_d = cnt_q;
        if (commit_ok) begin
            cnt_d = '0;
        end else if (ccff_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            chain_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            done_q  <= commit_ok;
            if (commit_bad) begin
                err_q <= 1'b1;
            end
            // Active routing switches on the same edge that accepts the commit.
            if (commit_ok) begin
                active_q <= chain_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (ccff_en) begin
                        state_q <= (cnt_d == CNT_MAX) ? FULL : SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_d == CNT_MAX) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (commit_ok) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    // A shift arriving during the done cycle starts a new load.
                    if (ccff_en) begin
                        state_q <= (cnt_d == CNT_MAX) ? FULL : SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ccff_tail = chain_q[CFG_BITS-1];
    assign cfg_full  = (state_q == FULL);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    for (genvar gi = 0; gi < CHAN_W; gi++) begin : g_track
        localparam int INC_IDX = (gi + 1) % CHAN_W;
        localparam int DEC_IDX = (gi + CHAN_W - 1) % CHAN_W;

        sb_track_mux4 u_right_mux (
            .sel_i      (active_q[SEL_BITS*gi +: SEL_BITS]),
            .straight_i (chanx_left_in[gi]),
            .inc_i      (chanx_left_in[INC_IDX]),
            .dec_i      (chanx_left_in[DEC_IDX]),
            .out_o      (chanx_right_out[gi])
        );

        sb_track_mux4 u_left_mux (
            .sel_i      (active_q[SEL_BITS*CHAN_W + SEL_BITS*gi +: SEL_BITS]),
            .straight_i (chanx_right_in[gi]),
            .inc_i      (chanx_right_in[INC_IDX]),
            .dec_i      (chanx_right_in[DEC_IDX]),
            .out_o      (chanx_left_out[gi])
        );
    end

endmodule

// File: tb/tb_sb_chanx_cfg.sv
// ---------------------------------------------------------------------------
// tb_sb_chanx_cfg
// Directed bench for sb_chanx_cfg (CHAN_W = 32, 128-bit chain).
// ---------------------------------------------------------------------------
module tb_sb_chanx_cfg;

    logic        prog_clk = 1'b0;
    logic        pReset_n;
    logic        ccff_head;
    logic        ccff_en;
    logic        ccff_tail;
    logic        cfg_commit;
    logic        cfg_full;
    logic        cfg_done;
    logic        cfg_err;
    logic [31:0] chanx_left_in;
    logic [31:0] chanx_right_in;
    logic [31:0] chanx_left_out;
    logic [31:0] chanx_right_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Whole-chain patterns: every 2-bit select field = 1, 2, 3.
    logic [127:0] pat_sel1;
    logic [127:0] pat_sel2;
    logic [127:0] pat_sel3;

    always #5 prog_clk = ~prog_clk;

    sb_chanx_cfg #(.CHAN_W(32)) dut (
        .prog_clk        (prog_clk),
        .pReset_n        (pReset_n),
        .ccff_head       (ccff_head),
        .ccff_en         (ccff_en),
        .ccff_tail       (ccff_tail),
        .cfg_commit      (cfg_commit),
        .cfg_full        (cfg_full),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err),
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head = b;
        ccff_en   = 1'b1;
        tick();
        ccff_en   = 1'b0;
    endtask

    // First bit shifted lands at the top of the chain, so send MSB first.
    task automatic load_word(input logic [127:0] w);
        for (int s = 0; s < 128; s++) begin
            shift_bit(w[127 - s]);
        end
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        pat_sel1 = {32{4'h5}};
        pat_sel2 = {32{4'hA}};
        pat_sel3 = {128{1'b1}};

        pReset_n       = 1'b0;
        ccff_head      = 1'b0;
        ccff_en        = 1'b0;
        cfg_commit     = 1'b0;
        chanx_left_in  = 32'hFFFF_FFFF;
        chanx_right_in = 32'hFFFF_FFFF;
        tick();
        tick();
        pReset_n = 1'b1;
        tick();

        // Reset state: everything off.
        $display("txn reset");
        check("rst_right_out", 64'(chanx_right_out), 64'h0);
        check("rst_left_out",  64'(chanx_left_out),  64'h0);
        check("rst_tail",      64'(ccff_tail),       64'h0);
        check("rst_err",       64'(cfg_err),         64'h0);
        check("rst_full",      64'(cfg_full),        64'h0);
        check("rst_done",      64'(cfg_done),        64'h0);

        // Straight routing: all selects = 1.
        $display("txn load sel=1 + commit");
        for (int s = 0; s < 127; s++) shift_bit(pat_sel1[127 - s]);
        check("full_at_127", 64'(cfg_full), 64'h0);
        shift_bit(pat_sel1[0]);
        check("full_at_128", 64'(cfg_full), 64'h1);
        check("pre_commit_out", 64'(chanx_right_out), 64'h0);
        do_commit();
        check("done_pulse", 64'(cfg_done), 64'h1);
        check("full_after_commit", 64'(cfg_full), 64'h0);
        tick();
        check("done_cleared", 64'(cfg_done), 64'h0);
        chanx_left_in  = 32'hA5A5_0F0F;
        chanx_right_in = 32'h1234_5678;
        #1;
        check("straight_right", 64'(chanx_right_out), 64'hA5A5_0F0F);
        check("straight_left",  64'(chanx_left_out),  64'h1234_5678);

        // i+1 routing with wrap.
        $display("txn load sel=2 + commit");
        load_word(pat_sel2);
        do_commit();
        chanx_left_in  = 32'h0000_0001;
        chanx_right_in = 32'h0000_0001;
        #1;
        check("inc_wrap_right", 64'(chanx_right_out), 64'h8000_0000);
        check("inc_wrap_left",  64'(chanx_left_out),  64'h8000_0000);

        // i-1 routing.
        $display("txn load sel=3 + commit");
        load_word(pat_sel3);
        do_commit();
        #1;
        check("dec_right", 64'(chanx_right_out), 64'h0000_0002);
        chanx_right_in = 32'h8000_0000;
        #1;
        check("dec_wrap_left", 64'(chanx_left_out), 64'h0000_0001);

        // Early commit is rejected.
        $display("txn short load (100 bits) + rejected commit");
        for (int s = 0; s < 100; s++) shift_bit(pat_sel1[127 - s]);
        do_commit();
        check("short_err",  64'(cfg_err),  64'h1);
        check("short_done", 64'(cfg_done), 64'h0);
        check("short_keep", 64'(chanx_right_out), 64'h0000_0002);

        $display("txn full reload sel=1 + commit with err sticky");
        load_word(pat_sel1);
        check("reload_full", 64'(cfg_full), 64'h1);
        do_commit();
        check("reload_done", 64'(cfg_done), 64'h1);
        check("reload_err",  64'(cfg_err),  64'h1);
        chanx_left_in = 32'hA5A5_0F0F;
        #1;
        check("reload_route", 64'(chanx_right_out), 64'hA5A5_0F0F);
        tick();

        // Old routing must hold throughout a new load.
        $display("txn load sel=2 while routing holds");
        for (int s = 0; s < 128; s++) begin
            shift_bit(pat_sel2[127 - s]);
            check("hold_route", 64'(chanx_right_out), 64'hA5A5_0F0F);
        end
        check("tail_first_bit", 64'(ccff_tail), 64'h1);
        cfg_commit = 1'b1;
        #1;
        check("hold_at_commit", 64'(chanx_right_out), 64'hA5A5_0F0F);
        tick();
        cfg_commit = 1'b0;
        // Rotate right by one: out[i] = in[i+1], out[31] = in[0].
        check("inc_route", 64'(chanx_right_out), 64'hD2D2_8787);
        tick();

        // Reset in the middle of a load.
        $display("txn reset during shift cycle 60");
        for (int s = 0; s < 60; s++) shift_bit(pat_sel1[127 - s]);
        pReset_n  = 1'b0;
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        tick();
        ccff_en  = 1'b0;
        pReset_n = 1'b1;
        check("mid_rst_full",  64'(cfg_full),        64'h0);
        check("mid_rst_right", 64'(chanx_right_out), 64'h0);
        check("mid_rst_tail",  64'(ccff_tail),       64'h0);
        check("mid_rst_err",   64'(cfg_err),         64'h0);

        // Counter restarted from zero: full after exactly 128 more shifts.
        $display("txn reload after reset + commit with shift");
        for (int s = 0; s < 127; s++) shift_bit(pat_sel1[127 - s]);
        check("rst_cnt_127", 64'(cfg_full), 64'h0);
        shift_bit(pat_sel1[0]);
        check("rst_cnt_128", 64'(cfg_full), 64'h1);
        cfg_commit = 1'b1;
        ccff_en    = 1'b1;
        ccff_head  = 1'b0;
        tick();
        cfg_commit = 1'b0;
        ccff_en    = 1'b0;
        check("en_commit_err",  64'(cfg_err),  64'h1);
        check("en_commit_done", 64'(cfg_done), 64'h0);
        check("en_commit_full", 64'(cfg_full), 64'h1);
        check("en_commit_out",  64'(chanx_right_out), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sb_chanx_cfg.md
Name: sb_chanx_cfg

Overview:
- Parametrised next-generation horizontal-channel switch block.
- Each output track on the left and right sides is driven from the opposite side's input tracks through a configurable 4:1 selector.
- The selector setting comes from a serial configuration chain with a double-buffered (shadow/active) register, so programming never glitches live routing.
- Sits in the routing fabric between CLB tiles and is chained with neighbouring blocks via ccff_head/ccff_tail.

Parameters:
- CHAN_W, 32, tracks per side.
- SEL_BITS, 2, select bits per output track (fixed encoding; not user-overridable).
- CFG_BITS, 4*CHAN_W, total chain length (derived localparam).

Ports:
- prog_clk  input  1  configuration/fabric clock
- pReset_n  input  1  synchronous active-low reset
- ccff_head  input  1  serial config data in
- ccff_en  input  1  shift enable for the chain
- ccff_tail  output  1  serial config data out (to next block)
- cfg_commit  input  1  single-cycle pulse: copy shift chain into the active register
- cfg_full  output  1  exactly CFG_BITS bits shifted since last commit/reset
- cfg_done  output  1  one-cycle pulse, the cycle after a successful commit
- cfg_err  output  1  sticky: a commit was rejected
- chanx_left_in  input  CHAN_W  left-side incoming tracks
- chanx_right_in  input  CHAN_W  right-side incoming tracks
- chanx_left_out  output  CHAN_W  left-side outgoing tracks
- chanx_right_out  output  CHAN_W  right-side outgoing tracks

Behaviour:
- Clock and reset: one clock, prog_clk. pReset_n is synchronous and active-low.
- Reset values: chain = 0, active = 0, bit counter = 0, state IDLE, cfg_full = 0, cfg_done = 0, cfg_err = 0.
- Outputs after reset: ccff_tail = 0; all chanx_*_out = 0, because select 0 means track off.
- Chain shift: when ccff_en = 1, chain[0] <= ccff_head and chain[k] <= chain[k-1]. ccff_tail = chain[CFG_BITS-1] (registered, 1-cycle-per-bit latency).
- Bit counter: increments on each shift and saturates at CFG_BITS. Extra shifts keep shifting data but do not change the count.
- State machine:
  - IDLE (count 0) -> SHIFT on the first shift.
  - SHIFT -> FULL when count reaches CFG_BITS.
  - FULL -> COMMIT on cfg_commit with ccff_en = 0.
  - COMMIT lasts one cycle: active <= chain, count <= 0, cfg_done = 1, next state IDLE.
  - The chain is not cleared by a commit.
- cfg_full = (state == FULL).
- Rejected commit: cfg_commit in IDLE/SHIFT, or asserted together with ccff_en. The commit is ignored and cfg_err is set. A coincident shift still happens.
- cfg_err clears only on reset.
- Select field map:
  - chanx_right_out[i] uses active[2i+1:2i].
  - chanx_left_out[i] uses active[2CHAN_W+2i+1 : 2CHAN_W+2i].
  - The first bit shifted in lands at the highest index.
- Select encoding for output i, with src = the opposite side's input:
  - 0 -> 0
  - 1 -> src[i]
  - 2 -> src[(i+1) mod CHAN_W]
  - 3 -> src[(i+CHAN_W-1) mod CHAN_W]
- Wrap-around: track CHAN_W-1 with sel 2 takes src[0]; track 0 with sel 3 takes src[CHAN_W-1].
- Data path: purely combinational from chanx_*_in and active; no latency. Active routing changes exactly on the commit clock edge.
- Reset mid-shift or mid-commit: everything returns to reset values the next edge, and outputs go to 0.

Decomposition:
- Shared package sb_cfg_pkg: sel encoding constants SEL_OFF = 0, SEL_STRAIGHT = 1, SEL_INC = 2, SEL_DEC = 3; state enum {IDLE, SHIFT, FULL, COMMIT}; function cfg_bits(chan_w).
- One sub-module, sb_track_mux4: one 4:1 output selector, instantiated 2*CHAN_W times via generate.
- The chain, counter and FSM stay in the top level.

Test Plan:
- Reset, then drive inputs 0xFFFFFFFF on both sides -> both outputs 0x00000000, ccff_tail = 0, cfg_err = 0.
- Shift 128 bits forming all selects = 1, then commit -> cfg_full high before the commit, cfg_done pulses one cycle after it; right_out = left_in and left_out = right_in for random data (e.g. left_in = 0xA5A5_0F0F gives right_out = 0xA5A5_0F0F).
- All selects = 2, left_in = 0x0000_0001 -> right_out = 0x8000_0000 (track 31 wraps to src[0]). All selects = 3 -> right_out = 0x0000_0002.
- Commit after only 100 shifts -> active unchanged, cfg_err = 1, no cfg_done pulse. A later full load plus commit succeeds while cfg_err stays 1.
- During a second 128-bit load, outputs keep the old routing every cycle until the commit edge. ccff_tail emits the first loaded bit after 128 shifts.
- pReset_n low during shift cycle 60 -> next cycle count = 0, outputs 0, cfg_full = 0. Commit with ccff_en = 1 in FULL -> rejected, cfg_err = 1.
